// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side drain logic.
//   - drain_state_t : drain controller states {IDLE, RUN, FLUSH}
//   - SKID_DEPTH    : number of words held by the output skid buffer
//   - clog2_min1()  : counter width helper that never returns 0
// Optional feature macro used by the drain controller: FIFO_DRAIN_LAST_EN
// -----------------------------------------------------------------------------
package fifo_pkg;

   // State encodings kept as plain constants so older code can compare against
   // them directly; the enum below reuses the same values.
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      FLUSH = ST_FLUSH
   } drain_state_t;

   localparam int unsigned SKID_DEPTH = 2;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry in-order word buffer sitting between the FIFO read port and the
// output stream. head_q is always the oldest word; tail_q the younger one.
// Ports:
//   clk_i   in   clock
//   rst_i   in   synchronous active-high reset; empties buffer, clears data
//   push_i  in   write data_i into the buffer this cycle
//   data_i  in   WIDTH  word to write
//   pop_i   in   remove the oldest word this cycle
//   data_o  out  WIDTH  oldest buffered word
//   occ_o   out  2      number of buffered words (0..2)
// A push into a full buffer or a pop from an empty one is ignored; the caller's
// credit logic keeps both from happening.
// -----------------------------------------------------------------------------
module fifo_skid_buf
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [1:0]       occ_o
);

   localparam logic [1:0] FULL = 2'(SKID_DEPTH);

   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [1:0]       occ_q, occ_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (occ_q != FULL);
   assign pop_ok  = pop_i  && (occ_q != 2'd0);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      unique case ({push_ok, pop_ok})
         2'b10: begin
            if (occ_q == 2'd0) head_d = data_i;
            else               tail_d = data_i;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            // Occupancy stays put; the new word lands behind whatever remains.
            if (occ_q == 2'd1) begin
               head_d = data_i;
            end else begin
               head_d = tail_q;
               tail_d = data_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   assign data_o = head_q;
   assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_drain_stream.sv
// -----------------------------------------------------------------------------
// fifo_drain_stream
// Read-side drain controller: pops words from the FIFO read port and presents
// them as a valid/ready stream at up to one word per cycle. A 2-entry skid
// buffer absorbs the FIFO's one-cycle read latency. Also counts delivered words
// and keeps a sticky underflow error flag.
// Optional feature: define FIFO_DRAIN_LAST_EN to generate m_last every
// FRAME_LEN delivered words; otherwise m_last is constant 0.
// Ports:
//   r_clk          in   clock
//   rst            in   synchronous active-high reset
//   drain_en       in   1 = drain the FIFO, 0 = stop popping and flush
//   fifo_empty     in   FIFO empty flag
//   fifo_underflow in   FIFO underflow flag
//   fifo_rd_en     out  FIFO pop request (combinational)
//   fifo_rdata     in   WIDTH  FIFO read data, valid the cycle after a pop
//   m_valid        out  stream valid
//   m_ready        in   stream ready
//   m_data         out  WIDTH  stream data
//   m_last         out  frame-end marker
//   word_cnt       out  CNT_W  completed handshakes, wrapping
//   busy           out  controller not idle
//   err_underflow  out  sticky underflow error
// -----------------------------------------------------------------------------
module fifo_drain_stream
   import fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 16,
   parameter int FRAME_LEN = 4
) (
   input  logic             r_clk,
   input  logic             rst,
   input  logic             drain_en,
   input  logic             fifo_empty,
   input  logic             fifo_underflow,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rdata,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic [CNT_W-1:0] word_cnt,
   output logic             busy,
   output logic             err_underflow
);

   drain_state_t     state_q, state_d;
   logic             pend_q;
   logic [1:0]       occ;
   logic             hs;
   logic [2:0]       in_flight;
   logic [CNT_W-1:0] word_cnt_q;
   logic             err_q;

   assign hs      = m_valid && m_ready;
   assign m_valid = (occ != 2'd0);

   // Words already held plus the one arriving next cycle; a handshake this
   // cycle frees a slot, so it is added to the limit instead of subtracted
   // from the count to keep the arithmetic unsigned.
   assign in_flight  = {1'b0, occ} + {2'b00, pend_q};
   assign fifo_rd_en = !rst && drain_en && (state_q == RUN) && !fifo_empty
                       && (in_flight < (3'd2 + {2'b00, hs}));

   fifo_skid_buf #(
      .WIDTH (WIDTH)
   ) u_skid (
      .clk_i  (r_clk),
      .rst_i  (rst),
      .push_i (pend_q),
      .data_i (fifo_rdata),
      .pop_i  (hs),
      .data_o (m_data),
      .occ_o  (occ)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (drain_en) state_d = RUN;
         RUN:     if (!drain_en) state_d = FLUSH;
         FLUSH: begin
            if (drain_en)                          state_d = RUN;
            else if ((occ == 2'd0) && !pend_q)     state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         pend_q     <= 1'b0;
         word_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= fifo_rd_en;
         if (hs)             word_cnt_q <= word_cnt_q + CNT_W'(1);
         if (fifo_underflow) err_q      <= 1'b1;
      end
   end

   assign word_cnt      = word_cnt_q;
   assign err_underflow = err_q;
   assign busy          = (state_q != IDLE);

`ifdef FIFO_DRAIN_LAST_EN
   localparam int unsigned FW = clog2_min1(FRAME_LEN);
   localparam logic [FW-1:0] FRAME_MAX = FW'(FRAME_LEN - 1);

   // Frame position of the word at the head of the buffer; it keeps counting
   // across FLUSH/IDLE so frames continue where they left off.
   logic [FW-1:0] frame_q;

   always_ff @(posedge r_clk) begin
      if (rst) begin
         frame_q <= '0;
      end else if (hs) begin
         frame_q <= (frame_q == FRAME_MAX) ? '0 : frame_q + FW'(1);
      end
   end

   assign m_last = m_valid && (frame_q == FRAME_MAX);
`else
   // FRAME_LEN is a positive constant, so this folds to 0.
   assign m_last = m_valid && (FRAME_LEN == 0);
`endif

endmodule

// File: tb/tb_fifo_drain_stream.sv
module tb_fifo_drain_stream;

   localparam int WIDTH     = 8;
   localparam int CNT_W     = 4;   // small so the wrap is reached
   localparam int FRAME_LEN = 4;

   logic             r_clk = 1'b0;
   logic             rst;
   logic             drain_en;
   logic             fifo_empty;
   logic             fifo_underflow;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_rdata = '0;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic [CNT_W-1:0] word_cnt;
   logic             busy;
   logic             err_underflow;

   int checks   = 0;
   int failures = 0;

   // FIFO read-port model
   logic [7:0] mem [0:63];
   int         fill_cnt = 0;
   int         rd_idx   = 0;
   assign fifo_empty = (fill_cnt == rd_idx);

   // Monitor logs
   int         cyc = 0;
   int         pop_n = 0;
   int         bad_pop = 0;
   int         pop_cyc [0:255];
   int         hs_n = 0;
   logic [7:0] hs_data [0:255];
   logic       hs_last [0:255];
   int         hs_cyc  [0:255];

   always #5 r_clk = ~r_clk;

   fifo_drain_stream #(
      .WIDTH     (WIDTH),
      .CNT_W     (CNT_W),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .r_clk          (r_clk),
      .rst            (rst),
      .drain_en       (drain_en),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_rdata     (fifo_rdata),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last         (m_last),
      .word_cnt       (word_cnt),
      .busy           (busy),
      .err_underflow  (err_underflow)
   );

   always @(posedge r_clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         if (fifo_rd_en) begin
            if (fifo_empty) bad_pop = bad_pop + 1;
            pop_cyc[pop_n] = cyc;
            pop_n = pop_n + 1;
            fifo_rdata <= mem[rd_idx % 64];
            rd_idx     <= rd_idx + 1;
         end
         if (m_valid && m_ready) begin
            hs_data[hs_n] = m_data;
            hs_last[hs_n] = m_last;
            hs_cyc[hs_n]  = cyc;
            $display("hs #%0d data=%02h last=%0d cyc=%0d", hs_n, m_data, m_last, cyc);
            hs_n = hs_n + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge r_clk);
   endtask

   task automatic load(input int n, input logic [7:0] first);
      for (int k = 0; k < n; k++) mem[(fill_cnt + k) % 64] = first + 8'(k);
      fill_cnt = fill_cnt + n;
   endtask

   task automatic wait_wc(input logic [CNT_W-1:0] tgt, input string tag);
      int n = 0;
      while (word_cnt !== tgt && n < 100) begin
         @(negedge r_clk);
         n++;
      end
      chk(tag, 32'(word_cnt), 32'(tgt));
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 50) begin
         @(negedge r_clk);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      int pop_base;
      int hs_base;
      int hs_snap;
      logic exp_last;

      rst = 1'b1; drain_en = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;

      // Reset state
      tick(2);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err_underflow), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);

      // 1: draining an empty FIFO
      rst = 1'b0; drain_en = 1'b1;
      tick(5);
      chk("t1_pops", 32'(pop_n), 32'd0);
      chk("t1_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t1_m_valid", 32'(m_valid), 32'd0);
      chk("t1_word_cnt", 32'(word_cnt), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);

      // 2: eight words, downstream always ready
      pop_base = pop_n; hs_base = hs_n;
      m_ready = 1'b1;
      load(8, 8'h11);
      wait_wc(4'd8, "t2_word_cnt");
      chk("t2_latency", 32'(hs_cyc[hs_base] - pop_cyc[pop_base]), 32'd2);
      chk("t2_b2b", 32'(hs_cyc[hs_base + 7] - hs_cyc[hs_base]), 32'd7);
      for (int k = 0; k < 8; k++) begin
`ifdef FIFO_DRAIN_LAST_EN
         exp_last = ((k % 4) == 3);
`else
         exp_last = 1'b0;
`endif
         chk($sformatf("t2_data%0d", k), 32'(hs_data[hs_base + k]), 32'h11 + 32'(k));
         chk($sformatf("t2_last%0d", k), 32'(hs_last[hs_base + k]), 32'(exp_last));
      end

      // 3: stall the stream mid-transfer for 5 cycles
      pop_base = pop_n; hs_base = hs_n;
      load(8, 8'h11);
      wait_wc(4'd11, "t3_pre_stall");
      m_ready = 1'b0;
      tick(3);
      chk("t3_buffered", 32'((pop_n - pop_base) - (hs_n - hs_base)), 32'd2);
      chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("t3_valid_a", 32'(m_valid), 32'd1);
      chk("t3_data_a", 32'(m_data), 32'h14);
      tick(2);
      chk("t3_valid_b", 32'(m_valid), 32'd1);
      chk("t3_data_b", 32'(m_data), 32'h14);
      chk("t3_rd_en_b", 32'(fifo_rd_en), 32'd0);
      m_ready = 1'b1;
      wait_wc(4'd0, "t3_wrap");
      for (int k = 0; k < 8; k++)
         chk($sformatf("t3_data%0d", k), 32'(hs_data[hs_base + k]), 32'h11 + 32'(k));

      // 4: drain_en drops with a pop in flight
      m_ready = 1'b0;
      tick(1);
      pop_base = pop_n; hs_base = hs_n;
      load(3, 8'h5A);
      tick(1);
      chk("t4_one_pop", 32'(pop_n - pop_base), 32'd1);
      chk("t4_rd_en_before", 32'(fifo_rd_en), 32'd1);
      drain_en = 1'b0;
      #1;
      chk("t4_rd_en_after", 32'(fifo_rd_en), 32'd0);
      tick(1);
      chk("t4_busy", 32'(busy), 32'd1);
      chk("t4_valid", 32'(m_valid), 32'd1);
      chk("t4_data", 32'(m_data), 32'h5A);
      m_ready = 1'b1;
      wait_idle("t4_idle");
      chk("t4_word_cnt", 32'(word_cnt), 32'd1);
      chk("t4_hs_data", 32'(hs_data[hs_base]), 32'h5A);
      chk("t4_no_more_pops", 32'(pop_n - pop_base), 32'd1);
      tick(3);
      chk("t4_still_valid0", 32'(m_valid), 32'd0);

      // 6: sticky underflow, then reset mid-stream
      fifo_underflow = 1'b1;
      tick(1);
      fifo_underflow = 1'b0;
      chk("t6_err_set", 32'(err_underflow), 32'd1);
      tick(3);
      chk("t6_err_sticky", 32'(err_underflow), 32'd1);
      hs_base = hs_n;
      load(20, 8'h60);
      drain_en = 1'b1;
      wait_wc(4'd4, "t6_stream");
      chk("t6_order0", 32'(hs_data[hs_base]), 32'h5B);
      chk("t6_order1", 32'(hs_data[hs_base + 1]), 32'h5C);
      chk("t6_order2", 32'(hs_data[hs_base + 2]), 32'h60);
      rst = 1'b1;
      #1;
      chk("t6_rd_en_forced", 32'(fifo_rd_en), 32'd0);
      chk("t6_err_pre_rst", 32'(err_underflow), 32'd1);
      tick(1);
      chk("t6_m_valid", 32'(m_valid), 32'd0);
      chk("t6_m_data", 32'(m_data), 32'd0);
      chk("t6_m_last", 32'(m_last), 32'd0);
      chk("t6_word_cnt", 32'(word_cnt), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_err", 32'(err_underflow), 32'd0);
      hs_snap = hs_n;
      drain_en = 1'b0;
      rst = 1'b0;
      tick(3);
      chk("t6_no_hs", 32'(hs_n - hs_snap), 32'd0);
      chk("t6_valid_after", 32'(m_valid), 32'd0);

      chk("never_pop_empty", 32'(bad_pop), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
